ieeedrv_trk_sched: RTL
======================

# ieeedrv_trk_sched

Schedules disk-image track transfers for the 4040/8250 drive. Up to SUBDRV sub-drives share one SD block channel and one track-buffer port. The block latches per-drive track-load requests and arbitrates them round-robin. For each granted request it first writes back the old track if it is dirty, then reads the new track block by block. While a transfer is in progress it asserts `busy`, which stalls the controller CPU, its RRIOT and VIA, and RAM port B.

## Interface
Parameters:
- SUBDRV, 2, number of sub-drives (1 or 2).
- BLKS, 16, 512-byte SD blocks per track buffer (power of two, 2..64).

Ports (NS = SUBDRV-1):
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk_sys.
- req_load  in  [NS:0]  one-cycle pulse: sub-drive i requests track req_track[i].
- req_track  in  [7:0] x SUBDRV  requested track number; sampled only on the req_load pulse.
- dirty  in  [NS:0]  buffer of sub-drive i has been modified since it was loaded.
- dirty_clr  out  [NS:0]  one-cycle pulse after write-back of drive i completes.
- img_mounted  in  [NS:0]  pulse: image of drive i changed; invalidates that drive.
- sd_lba  out  32  block address = track*BLKS + blk.
- sd_rd  out  1  read request.
- sd_wr  out  1  write request.
- sd_ack  in  1  HPS acknowledge; high for the whole block transfer.
- buf_sel  out  [$clog2(SUBDRV>1?SUBDRV:2)-1:0]  sub-drive whose buffer is connected to the SD channel.
- buf_blk  out  6  current block index within the track.
- busy  out  1  transfer in progress.
- done  out  [NS:0]  one-cycle pulse: drive i now holds the track it requested.
- cur_track  out  [7:0] x SUBDRV  track currently held by each drive.
- valid  out  [NS:0]  cur_track[i] is meaningful.

## Operation
- **Per-drive registers.** Each drive has pend, tgt[7:0], cur_track, valid and a round-robin pointer rr.
- **Request latching.** On req_load[i]: pend[i]<=1 and tgt[i]<=req_track[i]. A new request on a drive that is still pending overwrites tgt; the last request wins.
- **IDLE.** If any pend is set, grant the first pending drive at or after rr (wrapping around), set g, clear pend[g], then go to CHECK. Otherwise stay in IDLE.
- **CHECK.**
  - If valid[g] and cur_track[g]==tgt[g]: go to FIN with no SD traffic.
  - Else if valid[g] and dirty[g]: blk<=0, go to WREQ.
  - Else: blk<=0, go to RREQ.
- **WREQ.** sd_wr=1 with sd_lba=cur_track[g]*BLKS+blk. When sd_ack rises, drop sd_wr and go to WACK.
- **WACK.** Wait for sd_ack to fall.
  - If blk==BLKS-1: pulse dirty_clr[g], set blk<=0, go to RREQ.
  - Otherwise: blk++, go to WREQ.
- **RREQ/RACK.** Same handshake as WREQ/WACK, using sd_rd and sd_lba=tgt[g]*BLKS+blk. After the last block, go to FIN.
- **FIN.** cur_track[g]<=tgt[g], valid[g]<=1, pulse done[g], rr<=g+1 (mod SUBDRV), go to IDLE.
- **Arithmetic.** sd_lba is computed in 32 bits and zero-extended, with no overflow. blk is 6 bits wide and counts 0..BLKS-1.
- **img_mounted[i].** Clears valid[i] and pend[i].
  - If g==i and the FSM is in WREQ/RREQ: abort immediately. Drop the request, go to IDLE, no done pulse.
  - If g==i and the FSM is in WACK/RACK: set an abort flag. When sd_ack falls, go to IDLE with no done pulse and no dirty_clr pulse.
  - A handshake already in flight is never truncated.
- **img_mounted and req_load in the same cycle, same drive.** The request wins: pend=1, valid=0.
- **Output routing.** buf_sel=g and buf_blk=blk during transfers; both hold their values otherwise.
- **busy.** High in every state other than IDLE.

## Timing
- Reset values:
  - All outputs 0: sd_rd, sd_wr, busy, done, dirty_clr, valid, cur_track, sd_lba, buf_sel, buf_blk.
  - Internal: FSM in IDLE, pend=0, rr=0.
- **Reset mid-transfer.** sd_rd/sd_wr drop on the next edge. A stray sd_ack is ignored in IDLE.
- **Request to busy.** A req_load pulse in cycle n gives pend at n+1, busy at n+2 and CHECK at n+2.
  - Request for the already-held track: done pulses at n+3, busy low at n+4.
- **SD request.** sd_rd/sd_wr is registered and asserted the cycle after the FSM enters RREQ/WREQ. sd_lba is stable from that cycle until sd_ack falls.
- **Next block.** The next request is asserted 1 cycle after the sd_ack falling edge is sampled. The block never holds sd_rd and sd_wr high together.
- **Clean load.** Takes BLKS handshakes plus 4 cycles overhead.
- **Dirty load.** Takes 2*BLKS handshakes; dirty_clr precedes done.
- **Simultaneous requests.** Served strictly one at a time in round-robin order. done pulses never overlap.

## Test plan
- **Clean load.** Reset; req_load[0] with track 5, BLKS=16; the HPS model acks each request after 3 cycles.
  - Expect 16 sd_rd with sd_lba 80..95.
  - Expect done[0]=1 for one cycle, cur_track[0]=5, valid[0]=1.
  - Expect busy low afterwards.
- **Dirty load.** Drive 0 holds track 5 with dirty=1; req_load[0] with track 7.
  - Expect sd_wr on lba 80..95, then a dirty_clr[0] pulse.
  - Then expect sd_rd on lba 112..127, then done[0].
- **Same track.** Request track 7 while drive 0 already holds it.
  - Expect no sd_rd/sd_wr, done[0] 3 cycles after the request, busy high for exactly 2 cycles.
- **Round-robin.** req_load[0] and req_load[1] pulse in the same cycle, with rr=0.
  - Expect drive 0 served, then drive 1.
  - Repeat with rr=1: drive 1 is served first.
- **Eject mid-read.** img_mounted[0] arrives during RACK of block 3.
  - Expect block 3's handshake to complete, then no further sd_rd.
  - Expect no done pulse, valid[0]=0, busy low.
- **Reset mid-write.** Assert reset while sd_wr=1.
  - Expect sd_wr=0 and busy=0 on the next edge, all valid bits cleared, and an ack arriving afterwards ignored.

Source files
------------

// File: rtl/ieeedrv_trk_sched.sv
// Track transfer scheduler for the 4040/8250 drive.
// Latches per-sub-drive track-load requests and serves them round-robin over one
// SD block channel. A dirty buffer is written back before the new track is read.
module ieeedrv_trk_sched #(
  parameter int SUBDRV = 2,
  parameter int BLKS   = 16
) (
  input  logic                                     clk_sys,
  input  logic                                     reset,
  input  logic [SUBDRV-1:0]                        req_load,
  input  logic [SUBDRV-1:0][7:0]                   req_track,
  input  logic [SUBDRV-1:0]                        dirty,
  output logic [SUBDRV-1:0]                        dirty_clr,
  input  logic [SUBDRV-1:0]                        img_mounted,
  output logic [31:0]                              sd_lba,
  output logic                                     sd_rd,
  output logic                                     sd_wr,
  input  logic                                     sd_ack,
  output logic [$clog2(SUBDRV > 1 ? SUBDRV : 2)-1:0] buf_sel,
  output logic [5:0]                               buf_blk,
  output logic                                     busy,
  output logic [SUBDRV-1:0]                        done,
  output logic [SUBDRV-1:0][7:0]                   cur_track,
  output logic [SUBDRV-1:0]                        valid
);

  localparam int GW     = $clog2(SUBDRV > 1 ? SUBDRV : 2);
  localparam int BLK_SH = $clog2(BLKS);
  localparam logic [5:0] LAST_BLK = 6'(BLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WREQ  = 3'd2,
    S_WACK  = 3'd3,
    S_RREQ  = 3'd4,
    S_RACK  = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t                  state_r;
  logic [SUBDRV-1:0]       pend_r;
  logic [SUBDRV-1:0][7:0]  tgt_r;
  logic [SUBDRV-1:0][7:0]  cur_track_r;
  logic [SUBDRV-1:0]       valid_r;
  logic [SUBDRV-1:0]       done_r;
  logic [SUBDRV-1:0]       dirty_clr_r;
  logic [GW-1:0]           rr_r;
  logic [GW-1:0]           g_r;
  logic [GW-1:0]           buf_sel_r;
  logic [GW-1:0]           gnt_s;
  logic [7:0]              act_tgt_r;
  logic [5:0]              blk_r;
  logic [31:0]             sd_lba_r;
  logic                    sd_rd_r;
  logic                    sd_wr_r;
  logic                    busy_r;
  logic                    abort_r;
  logic                    ack_d_r;
  logic                    any_pend_s;
  logic                    grant_s;
  logic                    ack_rise_s;
  logic                    img_g_s;

  // Block address of a given track/block pair; never overflows 32 bits.
  function automatic logic [31:0] lba_of(input logic [7:0] trk, input logic [5:0] blk);
    lba_of = ({24'd0, trk} << BLK_SH) + {26'd0, blk};
  endfunction

  // Round-robin successor of a sub-drive index.
  function automatic logic [GW-1:0] next_drv(input logic [GW-1:0] d);
    if (int'(d) >= SUBDRV - 1) begin
      next_drv = '0;
    end else begin
      next_drv = d + GW'(1);
    end
  endfunction

  // Pick the first pending drive at or after the round-robin pointer.
  always_comb begin
    logic          found;
    logic [GW-1:0] idx;
    found = 1'b0;
    gnt_s = rr_r;
    idx   = rr_r;
    for (int k = 0; k < SUBDRV; k++) begin
      idx = GW'((int'(rr_r) + k) % SUBDRV);
      if (!found && pend_r[idx]) begin
        gnt_s = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    any_pend_s = |pend_r;
    grant_s    = (state_r == S_IDLE) && any_pend_s;
    ack_rise_s = sd_ack && !ack_d_r;
    img_g_s    = img_mounted[g_r];
  end

  // Latch per-drive requests; a new request beats an eject in the same cycle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_r <= '0;
      tgt_r  <= '0;
    end else begin
      for (int i = 0; i < SUBDRV; i++) begin
        if (req_load[i]) begin
          pend_r[i] <= 1'b1;
          tgt_r[i]  <= req_track[i];
        end else if (img_mounted[i]) begin
          pend_r[i] <= 1'b0;
        end else if (grant_s && gnt_s == GW'(i)) begin
          pend_r[i] <= 1'b0;
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
    end
  end

  // Transfer sequencer: write-back, read, completion and eject handling.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_r     <= S_IDLE;
      rr_r        <= '0;
      g_r         <= '0;
      buf_sel_r   <= '0;
      act_tgt_r   <= 8'd0;
      blk_r       <= 6'd0;
      sd_lba_r    <= 32'd0;
      sd_rd_r     <= 1'b0;
      sd_wr_r     <= 1'b0;
      busy_r      <= 1'b0;
      abort_r     <= 1'b0;
      done_r      <= '0;
      dirty_clr_r <= '0;
      valid_r     <= '0;
      cur_track_r <= '0;
      // Track the ack level so a stale ack is never seen as a fresh rise.
      ack_d_r     <= sd_ack;
    end else begin
      ack_d_r     <= sd_ack;
      done_r      <= '0;
      dirty_clr_r <= '0;
      case (state_r)
        S_IDLE: begin
          abort_r <= 1'b0;
          if (any_pend_s) begin
            g_r     <= gnt_s;
            busy_r  <= 1'b1;
            state_r <= S_CHECK;
          end else begin
            busy_r <= 1'b0;
          end
        end
        S_CHECK: begin
          act_tgt_r <= tgt_r[g_r];
          if (img_g_s) begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (valid_r[g_r] && cur_track_r[g_r] == tgt_r[g_r]) begin
            done_r[g_r] <= 1'b1;
            state_r     <= S_FIN;
          end else if (valid_r[g_r] && dirty[g_r]) begin
            blk_r     <= 6'd0;
            buf_sel_r <= g_r;
            state_r   <= S_WREQ;
          end else begin
            blk_r     <= 6'd0;
            buf_sel_r <= g_r;
            state_r   <= S_RREQ;
          end
        end
        S_WREQ: begin
          if (img_g_s && !(sd_wr_r && ack_rise_s)) begin
            sd_wr_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (!sd_wr_r) begin
            sd_wr_r  <= 1'b1;
            sd_lba_r <= lba_of(cur_track_r[g_r], blk_r);
          end else if (ack_rise_s) begin
            sd_wr_r <= 1'b0;
            abort_r <= img_g_s;
            state_r <= S_WACK;
          end else begin
            sd_wr_r <= 1'b1;
          end
        end
        S_WACK: begin
          if (sd_ack) begin
            abort_r <= abort_r | img_g_s;
          end else if (abort_r || img_g_s) begin
            abort_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (blk_r == LAST_BLK) begin
            dirty_clr_r[g_r] <= 1'b1;
            blk_r            <= 6'd0;
            state_r          <= S_RREQ;
          end else begin
            blk_r   <= blk_r + 6'd1;
            state_r <= S_WREQ;
          end
        end
        S_RREQ: begin
          if (img_g_s && !(sd_rd_r && ack_rise_s)) begin
            sd_rd_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (!sd_rd_r) begin
            sd_rd_r  <= 1'b1;
            sd_lba_r <= lba_of(act_tgt_r, blk_r);
          end else if (ack_rise_s) begin
            sd_rd_r <= 1'b0;
            abort_r <= img_g_s;
            state_r <= S_RACK;
          end else begin
            sd_rd_r <= 1'b1;
          end
        end
        S_RACK: begin
          if (sd_ack) begin
            abort_r <= abort_r | img_g_s;
          end else if (abort_r || img_g_s) begin
            abort_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else if (blk_r == LAST_BLK) begin
            done_r[g_r]      <= 1'b1;
            cur_track_r[g_r] <= act_tgt_r;
            valid_r[g_r]     <= 1'b1;
            state_r          <= S_FIN;
          end else begin
            blk_r   <= blk_r + 6'd1;
            state_r <= S_RREQ;
          end
        end
        S_FIN: begin
          valid_r[g_r] <= 1'b1;
          rr_r         <= next_drv(g_r);
          busy_r       <= 1'b0;
          state_r      <= S_IDLE;
        end
        default: begin
          sd_rd_r <= 1'b0;
          sd_wr_r <= 1'b0;
          busy_r  <= 1'b0;
          abort_r <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
      // A changed image invalidates its drive regardless of what the sequencer did.
      for (int i = 0; i < SUBDRV; i++) begin
        if (img_mounted[i]) begin
          valid_r[i] <= 1'b0;
        end
      end
    end
  end

  assign sd_lba    = sd_lba_r;
  assign sd_rd     = sd_rd_r;
  assign sd_wr     = sd_wr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign dirty_clr = dirty_clr_r;
  assign valid     = valid_r;
  assign cur_track = cur_track_r;
  assign buf_sel   = buf_sel_r;
  assign buf_blk   = blk_r;

endmodule
